// File: rtl/uart_baud_generator.sv
// Baud-rate tick generator: fractional divider producing oversampling, bit-boundary
// and mid-bit strobes for eight selectable UART rates, with synchronous realign.
module uart_baud_generator #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int FRAC_BITS  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          restart,
  input  logic [2:0]                    baud_select,
  output logic                          sample_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] bit_phase,
  output logic                          rate_pending
);

  localparam int PHASE_W = $clog2(OVERSAMPLE);
  localparam int FW      = (FRAC_BITS > 0) ? FRAC_BITS : 1;

  function automatic longint baud_of(input logic [2:0] r);
    case (r)
      3'd0:    return longint'(1200);
      3'd1:    return longint'(4800);
      3'd2:    return longint'(9600);
      3'd3:    return longint'(19200);
      3'd4:    return longint'(38400);
      3'd5:    return longint'(57600);
      3'd6:    return longint'(115200);
      default: return longint'(230400);
    endcase
  endfunction

  // Rounded divisor in units of 2^-FRAC_BITS clock cycles per sample.
  function automatic longint div_of(input logic [2:0] r);
    longint num;
    longint den;
    num = longint'(CLK_HZ) << FRAC_BITS;
    den = baud_of(r) * longint'(OVERSAMPLE);
    return (longint'(2) * num + den) / (longint'(2) * den);
  endfunction

  localparam longint D_SLOW = div_of(3'd0);
  localparam int     CNT_W  = $clog2((D_SLOW >> FRAC_BITS) + longint'(2));

  function automatic logic [CNT_W-1:0] int_of(input logic [2:0] r);
    return CNT_W'(div_of(r) >> FRAC_BITS);
  endfunction

  function automatic logic [FW-1:0] frac_of(input logic [2:0] r);
    return FW'(div_of(r) % (longint'(1) << FRAC_BITS));
  endfunction

  localparam logic [CNT_W-1:0] I_TAB [8] = '{
    int_of(3'd0), int_of(3'd1), int_of(3'd2), int_of(3'd3),
    int_of(3'd4), int_of(3'd5), int_of(3'd6), int_of(3'd7)
  };
  localparam logic [FW-1:0] F_TAB [8] = '{
    frac_of(3'd0), frac_of(3'd1), frac_of(3'd2), frac_of(3'd3),
    frac_of(3'd4), frac_of(3'd5), frac_of(3'd6), frac_of(3'd7)
  };

  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] PHASE_MID  = PHASE_W'(OVERSAMPLE / 2 - 1);

  for (genvar g = 0; g < 8; g++) begin : g_div_check
    if ((div_of(3'(g)) >> FRAC_BITS) < longint'(2)) begin : g_too_fast
      $error("uart_baud_generator: integer divisor below 2 for rate %0d", g);
    end
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_check
    $error("uart_baud_generator: OVERSAMPLE must be a power of two >= 4");
  end
  if (FRAC_BITS < 0 || FRAC_BITS > 8) begin : g_frac_check
    $error("uart_baud_generator: FRAC_BITS must be within 0..8");
  end

  logic [2:0]         sel_r;
  logic [2:0]         rate_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [FW-1:0]      acc_r;
  logic [PHASE_W-1:0] phase_r;
  logic               sample_tick_r;
  logic               bit_tick_r;
  logic               mid_tick_r;

  logic               tick_s;
  logic               bit_end_s;
  logic               mid_s;
  logic [FW:0]        sum_s;
  logic [2:0]         next_rate_s;
  logic [CNT_W-1:0]   load_i_s;
  logic [CNT_W-1:0]   carry_ext_s;

  // Tick decode, fractional add and the divisor for the next load.
  always_comb begin
    tick_s      = enable && (cnt_r == {CNT_W{1'b0}});
    bit_end_s   = tick_s && (phase_r == PHASE_LAST);
    mid_s       = tick_s && (phase_r == PHASE_MID);
    sum_s       = {1'b0, acc_r} + {1'b0, F_TAB[rate_r]};
    if (restart || bit_end_s) begin
      next_rate_s = sel_r;
    end else begin
      next_rate_s = rate_r;
    end
    load_i_s    = I_TAB[next_rate_s];
    carry_ext_s = {{(CNT_W-1){1'b0}}, sum_s[FW]};
  end

  // Register baud_select so a rate change never races the period logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r <= 3'd0;
    end else begin
      sel_r <= baud_select;
    end
  end

  // Period counter, fractional accumulator, bit phase, active rate and tick registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_r        <= 3'd0;
      cnt_r         <= I_TAB[3'd0] - CNT_ONE;
      acc_r         <= {FW{1'b0}};
      phase_r       <= {PHASE_W{1'b0}};
      sample_tick_r <= 1'b0;
      bit_tick_r    <= 1'b0;
      mid_tick_r    <= 1'b0;
    end else if (restart) begin
      rate_r        <= next_rate_s;
      cnt_r         <= load_i_s - CNT_ONE;
      acc_r         <= {FW{1'b0}};
      phase_r       <= {PHASE_W{1'b0}};
      sample_tick_r <= 1'b0;
      bit_tick_r    <= 1'b0;
      mid_tick_r    <= 1'b0;
    end else if (enable) begin
      sample_tick_r <= tick_s;
      bit_tick_r    <= bit_end_s;
      mid_tick_r    <= mid_s;
      if (tick_s) begin
        // The carry of this add stretches the period that starts now.
        rate_r  <= next_rate_s;
        cnt_r   <= load_i_s - CNT_ONE + carry_ext_s;
        acc_r   <= sum_s[FW-1:0];
        phase_r <= phase_r + PHASE_ONE;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end else begin
      sample_tick_r <= 1'b0;
      bit_tick_r    <= 1'b0;
      mid_tick_r    <= 1'b0;
    end
  end

  assign sample_tick  = sample_tick_r;
  assign bit_tick     = bit_tick_r;
  assign mid_tick     = mid_tick_r;
  assign bit_phase    = phase_r;
  assign rate_pending = (sel_r != rate_r);

endmodule
